// File: rtl/hazard_ctrl.sv
// Load-use / redirect / mem-stall hazard control owning the X and WB destination pipeline registers.
// Stage state and counters are registered; stall_pc, stall_id and flush_id are combinational.
module hazard_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       id_valid,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_uses_rs1,
  input  logic       id_uses_rs2,
  input  logic [4:0] id_rd,
  input  logic       id_rf_wen,
  input  logic [6:0] id_opcode,
  input  logic       redirect_X,
  input  logic       mem_stall,
  output logic       valid_X,
  output logic       valid_WB,
  output logic [4:0] rd_X,
  output logic [4:0] rd_WB,
  output logic       rf_wen_X,
  output logic       rf_wen_WB,
  output logic [6:0] opcode_X,
  output logic [6:0] opcode_WB,
  output logic       stall_pc,
  output logic       stall_id,
  output logic       flush_id,
  output logic [15:0] load_use_cnt,
  output logic [15:0] flush_cnt
);

  localparam logic [6:0] OPC_LOAD = 7'h03;
  localparam logic [6:0] OPC_NOP  = 7'h13;

  logic        valid_x_q, valid_x_d, valid_wb_q, valid_wb_d;
  logic [4:0]  rd_x_q, rd_x_d, rd_wb_q, rd_wb_d;
  logic        rf_wen_x_q, rf_wen_x_d, rf_wen_wb_q, rf_wen_wb_d;
  logic [6:0]  opcode_x_q, opcode_x_d, opcode_wb_q, opcode_wb_d;
  logic [15:0] load_use_cnt_q, load_use_cnt_d, flush_cnt_q, flush_cnt_d;
  logic        lu, redir;

  assign lu = id_valid & valid_x_q & (opcode_x_q == OPC_LOAD) & (rd_x_q != 5'd0) &
              ((id_uses_rs1 & (id_rs1 == rd_x_q)) | (id_uses_rs2 & (id_rs2 == rd_x_q)));
  assign redir = redirect_X & valid_x_q;

  always_comb begin
    valid_x_d      = valid_x_q;
    rd_x_d         = rd_x_q;
    rf_wen_x_d     = rf_wen_x_q;
    opcode_x_d     = opcode_x_q;
    valid_wb_d     = valid_wb_q;
    rd_wb_d        = rd_wb_q;
    rf_wen_wb_d    = rf_wen_wb_q;
    opcode_wb_d    = opcode_wb_q;
    load_use_cnt_d = load_use_cnt_q;
    flush_cnt_d    = flush_cnt_q;
    stall_pc       = 1'b0;
    stall_id       = 1'b0;
    flush_id       = 1'b0;

    if (mem_stall) begin
      stall_pc = 1'b1;
      stall_id = 1'b1;
    end else begin
      valid_wb_d  = valid_x_q;
      rd_wb_d     = rd_x_q;
      rf_wen_wb_d = rf_wen_x_q;
      opcode_wb_d = opcode_x_q;
      if (redir || lu) begin
        // Redirect wins over load-use: the stalled ID instruction is wrong-path anyway.
        valid_x_d  = 1'b0;
        rd_x_d     = 5'd0;
        rf_wen_x_d = 1'b0;
        opcode_x_d = OPC_NOP;
        if (redir) begin
          flush_id    = 1'b1;
          flush_cnt_d = (flush_cnt_q != 16'hFFFF) ? flush_cnt_q + 16'd1 : flush_cnt_q;
        end else begin
          stall_pc       = 1'b1;
          stall_id       = 1'b1;
          load_use_cnt_d = (load_use_cnt_q != 16'hFFFF) ? load_use_cnt_q + 16'd1 : load_use_cnt_q;
        end
      end else begin
        valid_x_d  = id_valid;
        rd_x_d     = id_rd;
        rf_wen_x_d = id_rf_wen & id_valid;
        opcode_x_d = id_opcode;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_x_q      <= 1'b0;
      rd_x_q         <= 5'd0;
      rf_wen_x_q     <= 1'b0;
      opcode_x_q     <= OPC_NOP;
      valid_wb_q     <= 1'b0;
      rd_wb_q        <= 5'd0;
      rf_wen_wb_q    <= 1'b0;
      opcode_wb_q    <= OPC_NOP;
      load_use_cnt_q <= 16'd0;
      flush_cnt_q    <= 16'd0;
    end else begin
      valid_x_q      <= valid_x_d;
      rd_x_q         <= rd_x_d;
      rf_wen_x_q     <= rf_wen_x_d;
      opcode_x_q     <= opcode_x_d;
      valid_wb_q     <= valid_wb_d;
      rd_wb_q        <= rd_wb_d;
      rf_wen_wb_q    <= rf_wen_wb_d;
      opcode_wb_q    <= opcode_wb_d;
      load_use_cnt_q <= load_use_cnt_d;
      flush_cnt_q    <= flush_cnt_d;
    end
  end

  assign valid_X      = valid_x_q;
  assign valid_WB     = valid_wb_q;
  assign rd_X         = rd_x_q;
  assign rd_WB        = rd_wb_q;
  assign rf_wen_X     = rf_wen_x_q;
  assign rf_wen_WB    = rf_wen_wb_q;
  assign opcode_X     = opcode_x_q;
  assign opcode_WB    = opcode_wb_q;
  assign load_use_cnt = load_use_cnt_q;
  assign flush_cnt    = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: reset, load-use, x0 loads, redirect priority, mem_stall freeze, saturation.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_uses_rs1, id_uses_rs2, id_rf_wen;
  logic [6:0]  id_opcode;
  logic        redirect_X, mem_stall;
  logic        valid_X, valid_WB;
  logic [4:0]  rd_X, rd_WB;
  logic        rf_wen_X, rf_wen_WB;
  logic [6:0]  opcode_X, opcode_WB;
  logic        stall_pc, stall_id, flush_id;
  logic [15:0] load_use_cnt, flush_cnt;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  hazard_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .id_rd(id_rd), .id_rf_wen(id_rf_wen), .id_opcode(id_opcode),
    .redirect_X(redirect_X), .mem_stall(mem_stall),
    .valid_X(valid_X), .valid_WB(valid_WB), .rd_X(rd_X), .rd_WB(rd_WB),
    .rf_wen_X(rf_wen_X), .rf_wen_WB(rf_wen_WB),
    .opcode_X(opcode_X), .opcode_WB(opcode_WB),
    .stall_pc(stall_pc), .stall_id(stall_id), .flush_id(flush_id),
    .load_use_cnt(load_use_cnt), .flush_cnt(flush_cnt)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs1, input logic u1,
                        input logic [4:0] rs2, input logic u2,
                        input logic [4:0] rd, input logic w, input logic [6:0] opc);
    id_valid = v; id_rs1 = rs1; id_uses_rs1 = u1; id_rs2 = rs2; id_uses_rs2 = u2;
    id_rd = rd; id_rf_wen = w; id_opcode = opc;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; redirect_X = 1'b0; mem_stall = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0, 7'h13);
    @(negedge clk);
    #1;
    check("rst_valid_x", {15'd0, valid_X}, 16'd0);
    check("rst_opcode_x", {9'd0, opcode_X}, 16'h13);
    check("rst_opcode_wb", {9'd0, opcode_WB}, 16'h13);
    check("rst_lu_cnt", load_use_cnt, 16'd0);
    check("rst_stall_pc", {15'd0, stall_pc}, 16'd0);

    // lw x5 followed by add x6,x5,x1
    rst_n = 1'b1;
    set_id(1, 5'd1, 1, 5'd0, 0, 5'd5, 1, 7'h03);
    tick();
    check("lw_in_x_valid", {15'd0, valid_X}, 16'd1);
    check("lw_in_x_rd", {11'd0, rd_X}, 16'd5);
    check("lw_in_x_wen", {15'd0, rf_wen_X}, 16'd1);
    set_id(1, 5'd5, 1, 5'd1, 1, 5'd6, 1, 7'h33);
    #1;
    check("lu_stall_pc", {15'd0, stall_pc}, 16'd1);
    check("lu_stall_id", {15'd0, stall_id}, 16'd1);
    check("lu_flush_id", {15'd0, flush_id}, 16'd0);
    tick();
    check("bubble_valid_x", {15'd0, valid_X}, 16'd0);
    check("bubble_rd_x", {11'd0, rd_X}, 16'd0);
    check("bubble_opc_x", {9'd0, opcode_X}, 16'h13);
    check("lw_in_wb_rd", {11'd0, rd_WB}, 16'd5);
    check("lu_cnt_1", load_use_cnt, 16'd1);
    check("lu_released", {15'd0, stall_pc}, 16'd0);
    tick();
    check("add_in_x_rd", {11'd0, rd_X}, 16'd6);
    check("add_in_x_valid", {15'd0, valid_X}, 16'd1);
    check("bubble_in_wb", {15'd0, valid_WB}, 16'd0);

    // lw x0 followed by a consumer of x0
    set_id(1, 5'd2, 1, 5'd0, 0, 5'd0, 1, 7'h03);
    tick();
    set_id(1, 5'd0, 1, 5'd0, 1, 5'd10, 1, 7'h33);
    #1;
    check("x0_no_stall", {15'd0, stall_pc}, 16'd0);
    tick();
    check("x0_consumer_rd", {11'd0, rd_X}, 16'd10);
    check("x0_lu_cnt", load_use_cnt, 16'd1);

    // redirect and load-use in the same cycle
    set_id(1, 5'd3, 1, 5'd0, 0, 5'd7, 1, 7'h03);
    tick();
    set_id(1, 5'd4, 1, 5'd7, 1, 5'd11, 1, 7'h33);
    redirect_X = 1'b1;
    #1;
    check("redir_flush_id", {15'd0, flush_id}, 16'd1);
    check("redir_stall_pc", {15'd0, stall_pc}, 16'd0);
    check("redir_stall_id", {15'd0, stall_id}, 16'd0);
    tick();
    redirect_X = 1'b0;
    check("redir_bubble_x", {15'd0, valid_X}, 16'd0);
    check("redir_wb_rd", {11'd0, rd_WB}, 16'd7);
    check("redir_flush_cnt", flush_cnt, 16'd1);
    check("redir_lu_cnt", load_use_cnt, 16'd1);

    // mem_stall for 3 cycles with a pending load-use
    set_id(1, 5'd3, 1, 5'd0, 0, 5'd8, 1, 7'h03);
    tick();
    set_id(1, 5'd8, 1, 5'd0, 0, 5'd9, 1, 7'h33);
    mem_stall = 1'b1;
    redirect_X = 1'b1;
    #1;
    check("hold_stall_pc", {15'd0, stall_pc}, 16'd1);
    check("hold_stall_id", {15'd0, stall_id}, 16'd1);
    check("hold_no_flush", {15'd0, flush_id}, 16'd0);
    for (int c = 0; c < 3; c++) begin
      tick();
      check("hold_rd_x", {11'd0, rd_X}, 16'd8);
      check("hold_rd_wb", {11'd0, rd_WB}, 16'd0);
      check("hold_lu_cnt", load_use_cnt, 16'd1);
      check("hold_flush_cnt", flush_cnt, 16'd1);
    end
    mem_stall = 1'b0;
    redirect_X = 1'b0;
    #1;
    check("post_hold_lu", {15'd0, stall_pc}, 16'd1);
    tick();
    check("post_hold_bubble", {15'd0, valid_X}, 16'd0);
    check("post_hold_wb_rd", {11'd0, rd_WB}, 16'd8);
    check("post_hold_lu_cnt", load_use_cnt, 16'd2);
    tick();
    check("post_hold_dep_rd", {11'd0, rd_X}, 16'd9);

    // invalid ID instruction must not carry a write enable
    set_id(0, 5'd0, 0, 5'd0, 0, 5'd12, 1, 7'h33);
    tick();
    check("inv_valid_x", {15'd0, valid_X}, 16'd0);
    check("inv_wen_x", {15'd0, rf_wen_X}, 16'd0);
    check("dep_wen_wb", {15'd0, rf_wen_WB}, 16'd1);

    // saturation: preload near the top, then keep generating load-use events
    force dut.load_use_cnt_q = 16'hFFFD;
    #1;
    release dut.load_use_cnt_q;
    set_id(1, 5'd5, 1, 5'd0, 0, 5'd5, 1, 7'h03);
    for (int e = 1; e <= 4; e++) begin
      tick();
      tick();
      check("sat_lu_cnt", load_use_cnt, (e == 1) ? 16'hFFFE : 16'hFFFF);
    end

    // asynchronous reset with a live instruction in X
    tick();
    check("pre_rst_valid_x", {15'd0, valid_X}, 16'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid_x", {15'd0, valid_X}, 16'd0);
    check("arst_rd_x", {11'd0, rd_X}, 16'd0);
    check("arst_wen_x", {15'd0, rf_wen_X}, 16'd0);
    check("arst_valid_wb", {15'd0, valid_WB}, 16'd0);
    check("arst_opc_x", {9'd0, opcode_X}, 16'h13);
    check("arst_lu_cnt", load_use_cnt, 16'd0);
    check("arst_flush_cnt", flush_cnt, 16'd0);
    check("arst_stall_pc", {15'd0, stall_pc}, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    set_id(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 7'h13);
    tick();
    check("restart_stall_pc", {15'd0, stall_pc}, 16'd0);
    check("restart_flush_id", {15'd0, flush_id}, 16'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and stage-tracking controller for the three-stage (IF/ID, X, WB) RISC-V core. It owns the X and WB destination-register pipeline registers (rd, write enable, opcode, valid) that the forwarding logic consumes. It detects load-use hazards between ID and X, applies taken-branch/jump redirect flushes from X, and honours a global data-memory stall. It also keeps saturating performance counters for stall and flush cycles.

## Interface

- No parameters; widths are fixed by the ISA (5-bit register index, 7-bit opcode).

- clk  input  1  core clock; all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- id_valid  input  1  ID holds a real instruction
- id_rs1, id_rs2  input  5 each  ID source register indices
- id_uses_rs1, id_uses_rs2  input  1 each  ID instruction actually reads rs1/rs2
- id_rd  input  5  ID destination index
- id_rf_wen  input  1  ID instruction writes the register file
- id_opcode  input  7  ID opcode (`OPC_*` from Opcode.vh)
- redirect_X  input  1  branch taken or jump resolved in X (valid only when valid_X=1)
- mem_stall  input  1  data memory not ready; freeze the whole pipeline
- valid_X, valid_WB  output  1 each  stage holds a real instruction
- rd_X, rd_WB  output  5 each  registered destination indices
- rf_wen_X, rf_wen_WB  output  1 each  registered write enable, already ANDed with stage valid
- opcode_X, opcode_WB  output  7 each  registered opcodes
- stall_pc  output  1  hold PC (combinational)
- stall_id  output  1  hold IF/ID register (combinational)
- flush_id  output  1  squash the IF/ID register (combinational)
- load_use_cnt  output  16  saturating count of load-use bubble cycles
- flush_cnt  output  16  saturating count of redirect flushes

## Operation

- Load-use hazard, combinational:
  - lu = id_valid & valid_X & opcode_X==`OPC_LOAD & rd_X!=0 & ((id_uses_rs1 & id_rs1==rd_X) | (id_uses_rs2 & id_rs2==rd_X)).
- Redirect: redir = redirect_X & valid_X.
- Per-cycle action, strict priority mem_stall > redir > lu > advance:
  - HOLD (mem_stall=1): X, WB and counters keep their values; stall_pc=stall_id=1; flush_id=0.
  - FLUSH (redir=1): X ← bubble, because the ID instruction is wrong-path; WB ← X; flush_id=1; stall_pc=stall_id=0; flush_cnt+1. Redirect overrides a simultaneous lu.
  - BUBBLE (lu=1): X ← bubble; WB ← X; stall_pc=stall_id=1; flush_id=0; load_use_cnt+1.
  - ADVANCE: X ← {id_valid, id_rd, id_rf_wen & id_valid, id_opcode}; WB ← X; all controls 0.
- A bubble sets valid=0, rf_wen=0, rd=0 and opcode=7'h13 (OPC_ARI_ITYPE, i.e. NOP).
- rf_wen_X/WB are never 1 while the matching valid is 0.
- Counters saturate at 16'hFFFF; they do not wrap.

## Timing

- All stage outputs and counters are registered; stall_pc, stall_id and flush_id are combinational from current-cycle inputs and state.
- Reset, asynchronous and immediate on rst_n=0:
  - valid, rf_wen and rd are 0 for both stages; opcodes are 7'h13; counters are 0.
  - Combinational controls are 0 because valid_X=0.
- Latency: an ID instruction appears in X one cycle after an ADVANCE edge, and in WB one cycle after that unless HOLD intervenes.
- Load-use costs exactly one bubble. On the next cycle the load is in WB, so lu deasserts by construction and the dependent instruction advances.
- mem_stall during a pending lu: HOLD persists; the bubble is inserted on the first cycle mem_stall=0.
- Reset deasserted mid-stall: the pipeline restarts empty; no stale stall or flush is asserted.
- rd=0 never causes a stall, even for a load.

## Test plan

- Reset: rst_n=0 mid-run with valid_X=1 → all outputs are 0 (opcodes 7'h13) at once, without waiting for a clock edge; counters read 0.
- Load-use: `lw x5` then `add x6,x5,x1` → one cycle with stall_pc=stall_id=1 and valid_X=0 next; then the add enters X; load_use_cnt=1.
- Load to x0: `lw x0` then a consumer of x0 → no stall; load_use_cnt stays 0.
- Redirect vs lu: redirect_X=1 and lu=1 in the same cycle → flush_id=1, stall_pc=0, X becomes a bubble, flush_cnt=1, load_use_cnt=0.
- mem_stall for 3 cycles with a load in X → rd_X, rd_WB and counters are frozen for 3 cycles; then exactly one bubble is inserted.
- Saturation: preload counter activity with 65536 load-use events → load_use_cnt=16'hFFFF and holds.
